out_channel_checker: RTL and testbench
======================================

Name: out_channel_checker

Overview:
- Consumer end of the emulator's out channel. The emulator under test writes words to the out channel (`outMem[outMemPos]`, one word per `out` instruction); this block accepts that stream over a valid/ready handshake.
- Compares each word in order against a preloaded list of expected values, then drives `finished`/`success`. This replaces the hard-coded `outMem[i] == k` checks in the FPGA test top.
- Sits between the emulator core and board LEDs / test harness. Expected values are streamed in before the run.

Parameters:
- MemoryElementWidth, 12, width of each out-channel word and expected value.
- NExpected, 16, capacity of the expected-value store (maximum words checked).
- TimeoutCycles, 4096, cycles allowed in CHECK before a forced failing finish.

Ports:
- clock  input  1  single clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- loadValid  input  1  expected-value word present.
- loadData  input  MemoryElementWidth  expected value.
- loadReady  output  1  store accepting expected values.
- start  input  1  end of load phase; arm the checker.
- outValid  input  1  emulator presents an out-channel word.
- outData  input  MemoryElementWidth  out-channel word.
- outReady  output  1  checker accepting out words.
- programFinished  input  1  emulator has executed its last instruction (level).
- expectedCount  output  $clog2(NExpected+1)  number of expected values loaded.
- receivedCount  output  16  out words accepted, saturating at 65535.
- mismatchIndex  output  16  index of the first mismatching word; all-ones if none.
- timedOut  output  1  finish was forced by the timeout.
- finished  output  1  check complete; held until reset.
- success  output  1  valid only while `finished`=1.

Behaviour:
- Reset (reset=0, asynchronous, may occur in any state, mid-transfer included): state=LOAD, expectedCount=0, receivedCount=0, mismatchIndex=all-ones, timeout counter=0.
- Output values in reset: loadReady=1, outReady=0, timedOut=0, finished=0, success=0.
- Expected store contents are not cleared by reset; unwritten entries are never read.
- States are LOAD, CHECK, DONE. All outputs are registered.

LOAD:
- loadReady = (expectedCount < NExpected).
- On loadValid && loadReady: store[expectedCount] <= loadData; expectedCount increments.
- When the store is full, loadReady drops to 0 and further loadValid is ignored; no overwrite.
- start=1 moves to CHECK next cycle. If loadValid is accepted in the same cycle as start, that word is stored first.
- outValid is ignored in LOAD (outReady=0).
- start with expectedCount=0 is legal: the run then expects zero words.

CHECK:
- loadReady=0, outReady=1; the timeout counter increments every cycle.
- On outValid && outReady, with i=receivedCount:
  - if i < expectedCount and outData != store[i] and mismatchIndex is all-ones, set mismatchIndex <= i;
  - if i >= expectedCount (surplus word) and mismatchIndex is all-ones, set mismatchIndex <= i;
  - receivedCount increments, saturating.
- Comparison is full-width unsigned equality.
- programFinished=1 sampled in CHECK moves to DONE next cycle. A word accepted in that same cycle is counted and compared first.
- When the timeout counter reaches TimeoutCycles-1 without programFinished: move to DONE with timedOut=1.
- If programFinished and timeout coincide, programFinished wins (timedOut=0).
- start is ignored outside LOAD.

DONE:
- finished=1, outReady=0, loadReady=0; all counters frozen.
- success = !timedOut && mismatchIndex==all-ones && receivedCount==expectedCount.
- A short stream (fewer words than expected) therefore fails.
- Leaves DONE only via reset.
- Latency: finished/success rise 1 cycle after programFinished is sampled in CHECK.

Test Plan:
1. Load {2}, start, send outData=2, then programFinished -> finished=1, success=1, receivedCount=1, mismatchIndex=0xFFFF.
2. Load {2,5,7}, send {2,6,7}, programFinished -> success=0, mismatchIndex=1, receivedCount=3, timedOut=0.
3. Load {1,2}, send {1}, programFinished -> success=0 (short), mismatchIndex=0xFFFF. Load {1}, send {1,9} -> success=0, mismatchIndex=1.
4. Present NExpected+2 load words -> loadReady=0 after 16 accepted, expectedCount=16, last two ignored. Check 16 matching words -> success=1.
5. start, send nothing, keep programFinished=0 -> finished=1, timedOut=1, success=0 exactly TimeoutCycles cycles into CHECK. Same test with programFinished asserted on the timeout cycle -> timedOut=0.
6. Assert reset low mid-CHECK with outValid=1 -> outputs at reset values immediately (asynchronous), state=LOAD. Reload {4} and check 4 -> success=1.

Source files
------------

// File: rtl/out_channel_checker.sv
// -----------------------------------------------------------------------------
// out_channel_checker
//
// Consumer end of the emulator's out channel. Expected words are streamed in
// first (LOAD). After start the block checks every accepted out-channel word,
// in order, against that list (CHECK). When the emulator reports it has
// finished, or the run exceeds its cycle budget, it settles in DONE and drives
// finished/success until reset.
//
// Ports:
//   clock            single clock, all state changes on posedge
//   reset            asynchronous, active-low reset
//   loadValid/Data   expected-value stream; loadReady while the store has room
//   start            ends the load phase and arms the checker
//   outValid/Data    out-channel word stream; outReady while checking
//   programFinished  level, emulator executed its last instruction
//   expectedCount    number of expected values loaded
//   receivedCount    out words accepted (saturates at 65535)
//   mismatchIndex    index of the first bad word, all-ones if none
//   timedOut         finish was forced by the cycle budget
//   finished         check complete, held until reset
//   success          run passed; meaningful only while finished=1
// -----------------------------------------------------------------------------
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NExpected          = 16,
  parameter int TimeoutCycles      = 4096
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               loadValid,
  input  logic [MemoryElementWidth-1:0]      loadData,
  output logic                               loadReady,
  input  logic                               start,
  input  logic                               outValid,
  input  logic [MemoryElementWidth-1:0]      outData,
  output logic                               outReady,
  input  logic                               programFinished,
  output logic [$clog2(NExpected+1)-1:0]     expectedCount,
  output logic [15:0]                        receivedCount,
  output logic [15:0]                        mismatchIndex,
  output logic                               timedOut,
  output logic                               finished,
  output logic                               success
);

  localparam int CountWidth = $clog2(NExpected + 1);
  localparam int IndexWidth = (NExpected > 1) ? $clog2(NExpected) : 1;
  localparam int TimerWidth = $clog2(TimeoutCycles + 1);

  localparam logic [15:0]            NoMismatch       = 16'hFFFF;
  localparam logic [15:0]            ReceivedMax      = 16'hFFFF;
  localparam logic [CountWidth-1:0]  ExpectedCapacity = CountWidth'(NExpected);
  localparam logic [CountWidth-1:0]  CountOne         = CountWidth'(1'b1);
  localparam logic [TimerWidth-1:0]  TimerLast        = TimerWidth'(TimeoutCycles - 1);
  localparam logic [TimerWidth-1:0]  TimerOne         = TimerWidth'(1'b1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                         state_r;
  logic [MemoryElementWidth-1:0]  store_r [NExpected];
  logic [TimerWidth-1:0]          timeoutCount_r;

  logic                           loadFire_s;
  logic                           outFire_s;
  logic                           inRange_s;
  logic                           wordBad_s;
  logic                           timeoutHit_s;
  logic [CountWidth-1:0]          nextExpected_s;
  logic [15:0]                    nextReceived_s;
  logic [15:0]                    nextMismatch_s;
  logic [MemoryElementWidth-1:0]  storeWord_s;

  // Next-value logic for the counters and the first-mismatch capture.
  always_comb begin
    loadFire_s     = 1'b0;
    outFire_s      = 1'b0;
    inRange_s      = 1'b0;
    wordBad_s      = 1'b0;
    timeoutHit_s   = 1'b0;
    nextExpected_s = expectedCount;
    nextReceived_s = receivedCount;
    nextMismatch_s = mismatchIndex;
    storeWord_s    = store_r[receivedCount[IndexWidth-1:0]];

    // Capacity is tested directly so a full store never overwrites.
    loadFire_s = (state_r == LOAD) && loadValid && (expectedCount < ExpectedCapacity);
    if (loadFire_s) begin
      nextExpected_s = expectedCount + CountOne;
    end else begin
      nextExpected_s = expectedCount;
    end

    outFire_s = (state_r == CHECK) && outValid;
    inRange_s = receivedCount < 16'(expectedCount);

    // A surplus word (beyond the loaded list) counts as a mismatch.
    if (inRange_s) begin
      wordBad_s = (outData != storeWord_s);
    end else begin
      wordBad_s = 1'b1;
    end

    // Only the first bad index is recorded.
    if (outFire_s && wordBad_s && (mismatchIndex == NoMismatch)) begin
      nextMismatch_s = receivedCount;
    end else begin
      nextMismatch_s = mismatchIndex;
    end

    if (outFire_s && (receivedCount != ReceivedMax)) begin
      nextReceived_s = receivedCount + 16'd1;
    end else begin
      nextReceived_s = receivedCount;
    end

    timeoutHit_s = (timeoutCount_r == TimerLast);
  end

  // Expected-value store; deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (loadFire_s) begin
      store_r[expectedCount[IndexWidth-1:0]] <= loadData;
    end
  end

  // Phase sequencing with all outputs registered alongside the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= LOAD;
      expectedCount  <= '0;
      receivedCount  <= 16'd0;
      mismatchIndex  <= NoMismatch;
      timeoutCount_r <= '0;
      loadReady      <= 1'b1;
      outReady       <= 1'b0;
      timedOut       <= 1'b0;
      finished       <= 1'b0;
      success        <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          expectedCount <= nextExpected_s;
          if (start) begin
            // A word accepted together with start is already in nextExpected_s.
            state_r        <= CHECK;
            timeoutCount_r <= '0;
            loadReady      <= 1'b0;
            outReady       <= 1'b1;
          end else begin
            loadReady <= (nextExpected_s < ExpectedCapacity);
            outReady  <= 1'b0;
          end
        end

        CHECK: begin
          receivedCount  <= nextReceived_s;
          mismatchIndex  <= nextMismatch_s;
          timeoutCount_r <= timeoutCount_r + TimerOne;
          // programFinished takes priority over a coinciding timeout.
          if (programFinished) begin
            state_r  <= DONE;
            outReady <= 1'b0;
            finished <= 1'b1;
            timedOut <= 1'b0;
            success  <= (nextMismatch_s == NoMismatch) &&
                        (nextReceived_s == 16'(expectedCount));
          end else if (timeoutHit_s) begin
            state_r  <= DONE;
            outReady <= 1'b0;
            finished <= 1'b1;
            timedOut <= 1'b1;
            success  <= 1'b0;
          end else begin
            state_r  <= CHECK;
            outReady <= 1'b1;
          end
        end

        DONE: begin
          loadReady <= 1'b0;
          outReady  <= 1'b0;
          finished  <= 1'b1;
        end

        default: begin
          // Unreachable encoding: settle in a failing finished state.
          state_r   <= DONE;
          loadReady <= 1'b0;
          outReady  <= 1'b0;
          finished  <= 1'b1;
          success   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// -----------------------------------------------------------------------------
// tb_out_channel_checker
//
// Drives out_channel_checker with directed scenarios and randomized runs.
// A list-based model (expected list, received list, phase, CHECK-cycle count)
// yields every output; a negedge process compares the DUT against it each
// cycle, and directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_out_channel_checker;

  localparam int W    = 12;
  localparam int NExp = 16;
  localparam int TO   = 4096;

  logic          clock = 1'b0;
  logic          reset;
  logic          loadValid;
  logic [W-1:0]  loadData;
  logic          loadReady;
  logic          start;
  logic          outValid;
  logic [W-1:0]  outData;
  logic          outReady;
  logic          programFinished;
  logic [4:0]    expectedCount;
  logic [15:0]   receivedCount;
  logic [15:0]   mismatchIndex;
  logic          timedOut;
  logic          finished;
  logic          success;

  int total = 0;
  int bad   = 0;
  bit compareOn = 1'b0;

  // Model state
  logic [W-1:0] mExp[$];
  logic [W-1:0] mRecv[$];
  int           mPhase;        // 0 load, 1 check, 2 done
  int           mCheckCycles;
  bit           mTimedOut;

  logic [W-1:0] stim[$];

  out_channel_checker #(
    .MemoryElementWidth(W),
    .NExpected(NExp),
    .TimeoutCycles(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .loadValid(loadValid),
    .loadData(loadData),
    .loadReady(loadReady),
    .start(start),
    .outValid(outValid),
    .outData(outData),
    .outReady(outReady),
    .programFinished(programFinished),
    .expectedCount(expectedCount),
    .receivedCount(receivedCount),
    .mismatchIndex(mismatchIndex),
    .timedOut(timedOut),
    .finished(finished),
    .success(success)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    mExp.delete();
    mRecv.delete();
    mPhase       = 0;
    mCheckCycles = 0;
    mTimedOut    = 1'b0;
  endtask

  task automatic modelStep();
    if (reset == 1'b0) begin
      modelReset();
      return;
    end
    case (mPhase)
      0: begin
        if (loadValid && mExp.size() < NExp) mExp.push_back(loadData);
        if (start) begin
          mPhase       = 1;
          mCheckCycles = 0;
        end
      end
      1: begin
        if (outValid) mRecv.push_back(outData);
        mCheckCycles++;
        if (programFinished) mPhase = 2;
        else if (mCheckCycles == TO) begin
          mPhase    = 2;
          mTimedOut = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [15:0] mMismatch();
    for (int i = 0; i < mRecv.size(); i++) begin
      if (i >= mExp.size() || mRecv[i] != mExp[i]) return 16'(i);
    end
    return 16'hFFFF;
  endfunction

  function automatic bit mSuccess();
    return (mPhase == 2) && !mTimedOut && (mMismatch() == 16'hFFFF) &&
           (mRecv.size() == mExp.size());
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (compareOn) begin
      check("loadReady", 32'(loadReady), 32'(mPhase == 0 && mExp.size() < NExp));
      check("outReady", 32'(outReady), 32'(mPhase == 1));
      check("expectedCount", 32'(expectedCount), 32'(mExp.size()));
      check("receivedCount", 32'(receivedCount), 32'((mRecv.size() > 65535) ? 65535 : mRecv.size()));
      check("mismatchIndex", 32'(mismatchIndex), 32'(mMismatch()));
      check("timedOut", 32'(timedOut), 32'(mTimedOut));
      check("finished", 32'(finished), 32'(mPhase == 2));
      check("success", 32'(success), 32'(mSuccess()));
    end
  end

  task automatic tick();
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic clearInputs();
    loadValid = 1'b0; loadData = '0; start = 1'b0;
    outValid = 1'b0; outData = '0; programFinished = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    modelReset();
    clearInputs();
    tick();
    reset = 1'b1;
  endtask

  task automatic loadAndStart();
    foreach (stim[i]) begin
      loadValid = 1'b1;
      loadData  = stim[i];
      tick();
    end
    loadValid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendList();
    foreach (stim[i]) begin
      outValid = 1'b1;
      outData  = stim[i];
      tick();
    end
    outValid = 1'b0;
  endtask

  task automatic finishRun();
    programFinished = 1'b1;
    tick();
    programFinished = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clearInputs();
    modelReset();
    tick();
    tick();
    reset = 1'b1;
    compareOn = 1'b1;
    check("reset_loadReady", 32'(loadReady), 32'd1);
    check("reset_mismatch", 32'(mismatchIndex), 32'hFFFF);

    // 1: single matching word
    doReset();
    stim = '{12'd2};
    loadAndStart();
    sendList();
    finishRun();
    check("t1_finished", 32'(finished), 32'd1);
    check("t1_success", 32'(success), 32'd1);
    check("t1_received", 32'(receivedCount), 32'd1);
    check("t1_mismatch", 32'(mismatchIndex), 32'hFFFF);

    // 2: mismatch in the middle
    doReset();
    stim = '{12'd2, 12'd5, 12'd7};
    loadAndStart();
    stim = '{12'd2, 12'd6, 12'd7};
    sendList();
    finishRun();
    check("t2_success", 32'(success), 32'd0);
    check("t2_mismatch", 32'(mismatchIndex), 32'd1);
    check("t2_received", 32'(receivedCount), 32'd3);
    check("t2_timedOut", 32'(timedOut), 32'd0);

    // 3a: short stream
    doReset();
    stim = '{12'd1, 12'd2};
    loadAndStart();
    stim = '{12'd1};
    sendList();
    finishRun();
    check("t3a_success", 32'(success), 32'd0);
    check("t3a_mismatch", 32'(mismatchIndex), 32'hFFFF);

    // 3b: surplus word
    doReset();
    stim = '{12'd1};
    loadAndStart();
    stim = '{12'd1, 12'd9};
    sendList();
    finishRun();
    check("t3b_success", 32'(success), 32'd0);
    check("t3b_mismatch", 32'(mismatchIndex), 32'd1);

    // 4: overfill the store, then a full matching run
    doReset();
    stim.delete();
    for (int i = 0; i < NExp + 2; i++) stim.push_back(12'(100 + i));
    foreach (stim[i]) begin
      loadValid = 1'b1;
      loadData  = stim[i];
      tick();
    end
    loadValid = 1'b0;
    check("t4_loadReady", 32'(loadReady), 32'd0);
    check("t4_expected", 32'(expectedCount), 32'd16);
    start = 1'b1;
    tick();
    start = 1'b0;
    void'(stim.pop_back());
    void'(stim.pop_back());
    sendList();
    finishRun();
    check("t4_success", 32'(success), 32'd1);

    // 5a: timeout exactly TO cycles into CHECK
    doReset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (TO - 1) tick();
    check("t5a_notyet", 32'(finished), 32'd0);
    tick();
    check("t5a_finished", 32'(finished), 32'd1);
    check("t5a_timedOut", 32'(timedOut), 32'd1);
    check("t5a_success", 32'(success), 32'd0);

    // 5b: programFinished on the timeout cycle wins
    doReset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (TO - 1) tick();
    finishRun();
    check("t5b_finished", 32'(finished), 32'd1);
    check("t5b_timedOut", 32'(timedOut), 32'd0);
    check("t5b_success", 32'(success), 32'd1);

    // 6: asynchronous reset mid-CHECK with a word in flight
    doReset();
    stim = '{12'd3, 12'd8};
    loadAndStart();
    outValid = 1'b1;
    outData  = 12'd3;
    tick();
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    check("t6_loadReady", 32'(loadReady), 32'd1);
    check("t6_outReady", 32'(outReady), 32'd0);
    check("t6_finished", 32'(finished), 32'd0);
    check("t6_success", 32'(success), 32'd0);
    check("t6_timedOut", 32'(timedOut), 32'd0);
    check("t6_expected", 32'(expectedCount), 32'd0);
    check("t6_received", 32'(receivedCount), 32'd0);
    check("t6_mismatch", 32'(mismatchIndex), 32'hFFFF);
    clearInputs();
    tick();
    reset = 1'b1;
    stim = '{12'd4};
    loadAndStart();
    sendList();
    finishRun();
    check("t6_success_after", 32'(success), 32'd1);

    // Randomized runs
    for (int r = 0; r < 30; r++) begin
      int n;
      int m;
      doReset();
      n = $urandom_range(0, NExp + 2);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(12'($urandom_range(0, 4095)));
      foreach (stim[i]) begin
        while ($urandom_range(0, 3) == 0) begin
          loadValid = 1'b0;
          outValid = 1'($urandom_range(0, 1));
          outData = 12'($urandom_range(0, 4095));
          programFinished = 1'($urandom_range(0, 1));
          tick();
        end
        outValid = 1'b0;
        programFinished = 1'b0;
        loadValid = 1'b1;
        loadData  = stim[i];
        if (i == n - 1 && $urandom_range(0, 2) == 0) start = 1'b1;
        tick();
      end
      loadValid = 1'b0;
      if (start == 1'b0) begin
        start = 1'b1;
        tick();
      end
      start = 1'b0;
      m = $urandom_range(0, n + 2);
      for (int i = 0; i < m; i++) begin
        while ($urandom_range(0, 3) == 0) begin
          outValid = 1'b0;
          start = 1'($urandom_range(0, 1));
          tick();
        end
        start = 1'b0;
        outValid = 1'b1;
        if (i < n && $urandom_range(0, 7) != 0) outData = stim[i];
        else outData = 12'($urandom_range(0, 4095));
        if (i == m - 1 && $urandom_range(0, 1) == 0) programFinished = 1'b1;
        tick();
      end
      outValid = 1'b0;
      programFinished = 1'b1;
      tick();
      programFinished = 1'b0;
      repeat (2) begin
        outValid = 1'($urandom_range(0, 1));
        loadValid = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        tick();
      end
      clearInputs();
    end

    compareOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
